spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one spi_master_v2 instance.
REQ-002 Parameter DATA_WIDTH, default 8, SPI word width; matches the master.
REQ-003 Parameter CS_SEL_WIDTH, default 2, chip-select index width; matches the master.
REQ-004 Parameter TIMEOUT, default 1024, watchdog limit in clk cycles (used only with SPI_ARB_TIMEOUT_EN).
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req  in  NUM_REQ  per-requester transaction request level.
REQ-008 req_data  in  NUM_REQ*DATA_WIDTH  per-requester TX word, slice i = requester i.
REQ-009 req_len  in  NUM_REQ*4  per-requester byte count.
REQ-010 req_cs  in  NUM_REQ*CS_SEL_WIDTH  per-requester chip-select index.
REQ-011 gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-012 ack  out  NUM_REQ  one-cycle completion pulse to granted requester.
REQ-013 err  out  NUM_REQ  one-cycle error pulse to granted requester.
REQ-014 rdata  out  DATA_WIDTH  last RX word, valid in ack cycle, held until next ack.
REQ-015 arb_busy  out  1  high whenever state is not IDLE.
REQ-016 m_start  out  1  start pulse to master.
REQ-017 m_data_in / m_data_len / m_cs_sel  out  DATA_WIDTH / 4 / CS_SEL_WIDTH  muxed from granted requester.
REQ-018 m_busy  in  1; m_done  in  1; m_data_out  in  DATA_WIDTH  master status and RX data.

Function
REQ-019 FSM states SHALL be IDLE, START, WAIT, COMPLETE; encoding 2 bits.
REQ-020 IDLE: if any req bit high, SHALL register one-hot gnt to the round-robin winner and go to START next cycle; else stay.
REQ-021 Round-robin: search SHALL begin at index (last_winner+1) mod NUM_REQ; last_winner updates on every grant.
REQ-022 START: if granted req_len==0, SHALL skip master, pulse err, clear gnt, return to IDLE next cycle; else assert m_start for exactly this one cycle and go to WAIT.
REQ-023 WAIT: on m_done==1, SHALL capture m_data_out into rdata and go to COMPLETE.
REQ-024 COMPLETE: ack[winner]=1 for one cycle, rdata valid, gnt cleared at end of cycle, then IDLE.
REQ-025 Latency: m_done sampled in cycle N -> ack high in cycle N+1; next grant earliest in cycle N+3.
REQ-026 m_data_in/m_data_len/m_cs_sel SHALL be combinational mux of granted slice while gnt!=0, else all zero (master re-samples m_data_in per byte).
REQ-027 Requester dropping req while granted SHALL be ignored; transaction completes and ack is still issued.
REQ-028 Requester keeping req high through ack SHALL be re-arbitrated at lowest priority.
REQ-029 m_busy SHALL be used only for arb_busy qualification; an m_done seen outside WAIT SHALL be ignored.
REQ-030 At most one of ack/err SHALL be high in any cycle, and only in the gnt bit's position.

Reset
REQ-031 rst high at posedge SHALL force state IDLE, gnt=0, ack=0, err=0, rdata=0, m_start=0, arb_busy=0, last_winner=NUM_REQ-1 (requester 0 wins first), watchdog=0.
REQ-032 rst mid-transaction SHALL abort without ack/err; the bench resets the master concurrently.

Configuration
REQ-033 Macro SPI_ARB_TIMEOUT_EN defined: watchdog counts cycles in WAIT; at TIMEOUT-1 without m_done, SHALL pulse err, clear gnt, return to IDLE; counter clears on entering WAIT.
REQ-034 Macro undefined: no watchdog logic; WAIT persists until m_done; err arises only from req_len==0.

Verification
REQ-035 Reset, req=4'b0001, len=1, data=8'hA5, cs=2 -> gnt=0001, one m_start pulse, m_cs_sel=2, ack[0] one cycle after m_done, rdata=miso loopback word.
REQ-036 req=4'b1111 held, len=1 each -> grants in order 0,1,2,3,0; no requester granted twice before all others served.
REQ-037 req[2] with len=0 -> no m_start, err[2] pulse in cycle after START, gnt cleared, ack never high.
REQ-038 req[1] len=3, drop req after 2 cycles -> m_data_len=3 held, ack[1] still issued, rdata = third RX byte.
REQ-039 With SPI_ARB_TIMEOUT_EN, TIMEOUT=16, m_done stuck low -> err pulse 16 cycles after WAIT entry, return to IDLE; without macro FSM stays in WAIT.
REQ-040 rst asserted during WAIT -> next cycle all outputs at reset values, no ack/err, requester 0 wins next arbitration.

Source files
------------

// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one SPI master between NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts a stalled WAIT after TIMEOUT cycles.
module spi_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int CS_SEL_WIDTH = 2,
   parameter int TIMEOUT      = 1024
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   input  logic [NUM_REQ*4-1:0]             req_len,
   input  logic [NUM_REQ*CS_SEL_WIDTH-1:0]  req_cs,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [NUM_REQ-1:0]               ack,
   output logic [NUM_REQ-1:0]               err,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic                             arb_busy,
   output logic                             m_start,
   output logic [DATA_WIDTH-1:0]            m_data_in,
   output logic [3:0]                       m_data_len,
   output logic [CS_SEL_WIDTH-1:0]          m_cs_sel,
   input  logic                             m_busy,
   input  logic                             m_done,
   input  logic [DATA_WIDTH-1:0]            m_data_out
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      START    = 2'd1,
      WAIT     = 2'd2,
      COMPLETE = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        last_winner, last_winner_nxt;
   logic [IDX_W-1:0]        rr_idx, rr_cand;
   logic                    rr_found;
   logic [NUM_REQ-1:0]      gnt_nxt, ack_nxt, err_nxt;
   logic [DATA_WIDTH-1:0]   rdata_nxt;
   logic                    gnt_any;
   logic                    wdog_expired;

   logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
   logic [3:0]              len_arr  [NUM_REQ];
   logic [CS_SEL_WIDTH-1:0] cs_arr   [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign len_arr[i]  = req_len[i*4 +: 4];
      assign cs_arr[i]   = req_cs[i*CS_SEL_WIDTH +: CS_SEL_WIDTH];
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [WD_W-1:0] wdog, wdog_nxt;
   assign wdog_expired = (wdog == WD_W'(TIMEOUT - 1));
`else
   assign wdog_expired = 1'b0;
`endif

   // last_winner always names the granted requester while gnt is non-zero
   assign gnt_any = |gnt;

   always_comb begin
      m_data_in  = '0;
      m_data_len = '0;
      m_cs_sel   = '0;
      if (gnt_any) begin
         m_data_in  = data_arr[last_winner];
         m_data_len = len_arr[last_winner];
         m_cs_sel   = cs_arr[last_winner];
      end
   end

   assign m_start  = (state == START) && (m_data_len != 4'd0);
   assign arb_busy = (state != IDLE) || (m_busy && gnt_any);

   // Round-robin search starting just after the previous winner
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_cand = IDX_W'((int'(last_winner) + k) % NUM_REQ);
         if (!rr_found && req[rr_cand]) begin
            rr_found = 1'b1;
            rr_idx   = rr_cand;
         end
      end
   end

   always_comb begin
      state_nxt       = state;
      gnt_nxt         = gnt;
      ack_nxt         = '0;
      err_nxt         = '0;
      rdata_nxt       = rdata;
      last_winner_nxt = last_winner;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog_nxt        = wdog;
`endif
      case (state)
         IDLE: begin
            if (rr_found) begin
               gnt_nxt         = NUM_REQ'(1) << rr_idx;
               last_winner_nxt = rr_idx;
               state_nxt       = START;
            end
         end
         START: begin
            if (m_data_len == 4'd0) begin
               err_nxt   = gnt;
               gnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               state_nxt = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
               wdog_nxt  = '0;
`endif
            end
         end
         WAIT: begin
            if (m_done) begin
               rdata_nxt = m_data_out;
               ack_nxt   = gnt;
               state_nxt = COMPLETE;
            end else if (wdog_expired) begin
               err_nxt   = gnt;
               gnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
`ifdef SPI_ARB_TIMEOUT_EN
               wdog_nxt  = wdog + 1'b1;
`endif
            end
         end
         COMPLETE: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt         <= '0;
         ack         <= '0;
         err         <= '0;
         rdata       <= '0;
         last_winner <= IDX_W'(NUM_REQ - 1);
`ifdef SPI_ARB_TIMEOUT_EN
         wdog        <= '0;
`endif
      end else begin
         gnt         <= gnt_nxt;
         ack         <= ack_nxt;
         err         <= err_nxt;
         rdata       <= rdata_nxt;
         last_winner <= last_winner_nxt;
`ifdef SPI_ARB_TIMEOUT_EN
         wdog        <= wdog_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter with a behavioural SPI master (per-byte loopback).
module tb_spi_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req = '0;
   logic [31:0]  req_data;
   logic [15:0]  req_len;
   logic [7:0]   req_cs;
   logic [3:0]   gnt, ack, err;
   logic [7:0]   rdata;
   logic         arb_busy, m_start;
   logic [7:0]   m_data_in;
   logic [3:0]   m_data_len;
   logic [1:0]   m_cs_sel;
   logic         m_busy, m_done;
   logic [7:0]   m_data_out;

   logic [7:0]   d [4];
   logic [3:0]   l [4];
   logic [1:0]   c [4];
   bit           stuck = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] vec;
      bit         is_err;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   assign req_data = {d[3], d[2], d[1], d[0]};
   assign req_len  = {l[3], l[2], l[1], l[0]};
   assign req_cs   = {c[3], c[2], c[1], c[0]};

   always #5 clk = ~clk;

   spi_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .CS_SEL_WIDTH(2), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_len(req_len),
      .req_cs(req_cs), .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
      .arb_busy(arb_busy), .m_start(m_start), .m_data_in(m_data_in),
      .m_data_len(m_data_len), .m_cs_sel(m_cs_sel), .m_busy(m_busy),
      .m_done(m_done), .m_data_out(m_data_out)
   );

   // Master model: 3 clk per byte, RX byte k = m_data_in ^ k, m_done with last RX byte
   logic [1:0] tick;
   logic [3:0] bcnt, blen;
   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_data_out <= '0;
         tick <= '0; bcnt <= '0; blen <= '0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (m_start) begin
               m_busy <= 1'b1; blen <= m_data_len; bcnt <= '0; tick <= '0;
            end
         end else if (!stuck) begin
            if (tick == 2'd2) begin
               tick <= '0;
               bcnt <= bcnt + 4'd1;
               if (bcnt + 4'd1 == blen) begin
                  m_busy     <= 1'b0;
                  m_done     <= 1'b1;
                  m_data_out <= m_data_in ^ {4'h0, bcnt};
               end
            end else begin
               tick <= tick + 2'd1;
            end
         end
      end
   end

   // Scoreboard: every ack/err pulse must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && (ack != '0 || err != '0)) begin
         checks++;
         if (ack != '0 && err != '0) begin
            errors++;
            $display("FAIL ack_err_exclusive: ack=%b err=%b, required at most one", ack, err);
         end
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: ack=%b err=%b, required no pulse", ack, err);
         end else begin
            e = sb.pop_front();
            checks++;
            if (e.is_err && (err !== e.vec || ack !== 4'b0)) begin
               errors++;
               $display("FAIL sb_err: err=%b ack=%b, required err=%b", err, ack, e.vec);
            end
            if (!e.is_err) begin
               if (ack !== e.vec || err !== 4'b0) begin
                  errors++;
                  $display("FAIL sb_ack: ack=%b err=%b, required ack=%b", ack, err, e.vec);
               end
               checks++;
               if (rdata !== e.data) begin
                  errors++;
                  $display("FAIL sb_rdata: rdata=%h, required %h", rdata, e.data);
               end
            end
         end
      end
   end

   task automatic reset_dut();
      req = '0; stuck = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((arb_busy || sb.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL idle_timeout: busy=%b pending=%0d, required idle within %0d cycles",
                  arb_busy, sb.size(), budget);
         sb.delete();
      end
   endtask

   task automatic test_reset();
      reset_dut();
      checks += 7;
      if (gnt !== 4'b0)      begin errors++; $display("FAIL rst_gnt: %b, required 0", gnt); end
      if (ack !== 4'b0)      begin errors++; $display("FAIL rst_ack: %b, required 0", ack); end
      if (err !== 4'b0)      begin errors++; $display("FAIL rst_err: %b, required 0", err); end
      if (rdata !== 8'h00)   begin errors++; $display("FAIL rst_rdata: %h, required 0", rdata); end
      if (arb_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b, required 0", arb_busy); end
      if (m_start !== 1'b0)  begin errors++; $display("FAIL rst_mstart: %b, required 0", m_start); end
      if ({m_data_in, m_data_len, m_cs_sel} !== 14'h0) begin
         errors++; $display("FAIL rst_mux: %h/%h/%h, required 0", m_data_in, m_data_len, m_cs_sel);
      end
   endtask

   task automatic test_single();
      int starts = 0, done_at = -1, ack_at = -1;
      logic [3:0] ack_seen = '0;
      reset_dut();
      d[0] = 8'hA5; l[0] = 4'd1; c[0] = 2'd2;
      sb.push_back('{vec: 4'b0001, is_err: 1'b0, data: 8'hA5});
      req = 4'b0001;
      @(negedge clk);
      checks += 4;
      if (gnt !== 4'b0001)     begin errors++; $display("FAIL single_gnt: %b, required 0001", gnt); end
      if (m_cs_sel !== 2'd2)   begin errors++; $display("FAIL single_cs: %0d, required 2", m_cs_sel); end
      if (m_data_in !== 8'hA5) begin errors++; $display("FAIL single_data: %h, required a5", m_data_in); end
      if (arb_busy !== 1'b1)   begin errors++; $display("FAIL single_busy: %b, required 1", arb_busy); end
      req = 4'b0000;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (m_start) starts++;
         if (m_done) done_at = cyc;
         if (ack != '0) begin ack_at = cyc; ack_seen = ack; break; end
         @(negedge clk);
      end
      checks += 3;
      if (starts != 1)         begin errors++; $display("FAIL single_mstart: %0d pulses, required 1", starts); end
      if (ack_seen !== 4'b0001) begin errors++; $display("FAIL single_ack: %b, required 0001", ack_seen); end
      if (done_at < 0 || ack_at != done_at + 1) begin
         errors++; $display("FAIL single_latency: ack at %0d done at %0d, required done+1", ack_at, done_at);
      end
      @(negedge clk);
      checks += 3;
      if (ack !== 4'b0)      begin errors++; $display("FAIL single_ack_len: %b, required 0", ack); end
      if (gnt !== 4'b0)      begin errors++; $display("FAIL single_gnt_clr: %b, required 0", gnt); end
      if (rdata !== 8'hA5)   begin errors++; $display("FAIL single_rdata_hold: %h, required a5", rdata); end
      wait_idle(50);
   endtask

   task automatic test_round_robin();
      logic [3:0] got [5];
      logic [3:0] prev = '0;
      logic [3:0] want;
      int ngr = 0;
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         d[i] = 8'h10 + 8'(i); l[i] = 4'd1; c[i] = 2'(i);
      end
      for (int k = 0; k < 5; k++) begin
         got[k] = '0;
         sb.push_back('{vec: 4'b0001 << (k % 4), is_err: 1'b0, data: 8'h10 + 8'(k % 4)});
      end
      req = 4'b1111;
      for (int cyc = 0; cyc < 300 && ngr < 5; cyc++) begin
         @(negedge clk);
         if (gnt != '0 && prev == '0) begin got[ngr] = gnt; ngr++; end
         prev = gnt;
      end
      req = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         want = 4'b0001 << (k % 4);
         checks++;
         if (got[k] !== want) begin
            errors++; $display("FAIL rr_order[%0d]: %b, required %b", k, got[k], want);
         end
      end
      wait_idle(100);
   endtask

   task automatic test_zero_len();
      bit bad = 1'b0;
      reset_dut();
      d[2] = 8'h5A; l[2] = 4'd0; c[2] = 2'd1;
      sb.push_back('{vec: 4'b0100, is_err: 1'b1, data: 8'h00});
      req = 4'b0100;
      @(negedge clk);
      checks += 2;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL zl_gnt: %b, required 0100", gnt); end
      if (m_start !== 1'b0) begin errors++; $display("FAIL zl_mstart: %b, required 0", m_start); end
      req = 4'b0000;
      @(negedge clk);
      checks += 3;
      if (err !== 4'b0100) begin errors++; $display("FAIL zl_err: %b, required 0100", err); end
      if (gnt !== 4'b0)    begin errors++; $display("FAIL zl_gnt_clr: %b, required 0", gnt); end
      if (ack !== 4'b0)    begin errors++; $display("FAIL zl_ack: %b, required 0", ack); end
      repeat (5) begin
         @(negedge clk);
         if (ack != '0 || m_start) bad = 1'b1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL zl_quiet: ack/m_start seen, required none"); end
      wait_idle(20);
   endtask

   task automatic test_drop_req();
      bit bad_len = 1'b0;
      logic [3:0] ack_seen = '0;
      reset_dut();
      d[1] = 8'h3C; l[1] = 4'd3; c[1] = 2'd3;
      sb.push_back('{vec: 4'b0010, is_err: 1'b0, data: 8'h3C ^ 8'h02});
      req = 4'b0010;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_gnt: %b, required 0010", gnt); end
      repeat (2) @(negedge clk);
      req = 4'b0000;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (gnt != '0 && m_data_len !== 4'd3) bad_len = 1'b1;
         if (ack != '0) begin ack_seen = ack; break; end
         @(negedge clk);
      end
      checks += 3;
      if (bad_len)              begin errors++; $display("FAIL drop_len: m_data_len not held at 3"); end
      if (ack_seen !== 4'b0010) begin errors++; $display("FAIL drop_ack: %b, required 0010", ack_seen); end
      if (rdata !== 8'h3E)      begin errors++; $display("FAIL drop_rdata: %h, required 3e", rdata); end
      repeat (3) @(negedge clk);
      checks++;
      if (gnt !== 4'b0) begin errors++; $display("FAIL drop_regrant: %b, required 0", gnt); end
      wait_idle(20);
   endtask

   task automatic test_rst_in_wait();
      logic [3:0] first = '0;
      stuck = 1'b1;
      d[0] = 8'h77; l[0] = 4'd1; c[0] = 2'd0;
      req = 4'b0001;
      repeat (4) @(negedge clk);
      checks++;
      if (gnt !== 4'b0001 || !m_busy) begin
         errors++; $display("FAIL rw_pre: gnt=%b m_busy=%b, required 0001/1", gnt, m_busy);
      end
      rst = 1'b1;
      @(negedge clk);
      checks += 3;
      if ({gnt, ack, err} !== 12'h0) begin
         errors++; $display("FAIL rw_outs: gnt=%b ack=%b err=%b, required 0", gnt, ack, err);
      end
      if (rdata !== 8'h00) begin errors++; $display("FAIL rw_rdata: %h, required 0", rdata); end
      if (arb_busy !== 1'b0 || m_start !== 1'b0) begin
         errors++; $display("FAIL rw_busy: busy=%b m_start=%b, required 0", arb_busy, m_start);
      end
      rst = 1'b0; stuck = 1'b0;
      for (int i = 0; i < 4; i++) l[i] = 4'd1;
      sb.push_back('{vec: 4'b0001, is_err: 1'b0, data: 8'h77});
      req = 4'b1111;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (gnt != '0) begin first = gnt; break; end
      end
      req = 4'b0000;
      checks++;
      if (first !== 4'b0001) begin errors++; $display("FAIL rw_first: %b, required 0001", first); end
      wait_idle(50);
   endtask

   task automatic test_timeout();
      int err_at = -1;
      reset_dut();
      stuck = 1'b1;
      d[0] = 8'h42; l[0] = 4'd1;
`ifdef SPI_ARB_TIMEOUT_EN
      sb.push_back('{vec: 4'b0001, is_err: 1'b1, data: 8'h00});
`endif
      req = 4'b0001;
      @(negedge clk);
      req = 4'b0000;
      @(negedge clk);
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (err != '0 && err_at < 0) err_at = cyc;
         @(negedge clk);
      end
      checks += 2;
`ifdef SPI_ARB_TIMEOUT_EN
      if (err_at != 16) begin errors++; $display("FAIL to_err_at: %0d, required 16", err_at); end
      if (arb_busy !== 1'b0 || gnt !== 4'b0) begin
         errors++; $display("FAIL to_idle: busy=%b gnt=%b, required 0/0", arb_busy, gnt);
      end
`else
      if (err_at != -1) begin errors++; $display("FAIL to_err_at: %0d, required none", err_at); end
      if (arb_busy !== 1'b1 || gnt !== 4'b0001) begin
         errors++; $display("FAIL to_wait: busy=%b gnt=%b, required 1/0001", arb_busy, gnt);
      end
`endif
      reset_dut();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin d[i] = '0; l[i] = '0; c[i] = '0; end
      test_reset();
      test_single();
      test_round_robin();
      test_zero_len();
      test_drop_req();
      test_rst_in_wait();
      test_timeout();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_leftover: %0d pending, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
